// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared states and bus constants for the I2C burst reader
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR_W,
        ACK1,
        REG,
        ACK2,
        RSTART,
        ADDR_R,
        ACK3,
        RDATA,
        MACK,
        STOP
    } i2c_state_t;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;
    localparam logic ACK       = 1'b0;
    localparam logic NACK      = 1'b1;

    localparam int DEFAULT_SCL_HALF_TICKS = 10;

endpackage

// File: rtl/i2c_bit_timer.sv
// rtl/i2c_bit_timer.sv - per-bit phase counter, SCL shape and drive/sample/end strobes
module i2c_bit_timer #(
    parameter int SCL_HALF_TICKS = 10,
    parameter int PHASE_W        = $clog2(2 * SCL_HALF_TICKS)
) (
    input  logic               clk_200khz,
    input  logic               rst,
    input  logic               run,
    output logic [PHASE_W-1:0] phase,
    output logic               scl,
    output logic               drive_tick,
    output logic               sample_tick,
    output logic               bit_end
);

    localparam int H = SCL_HALF_TICKS;

    // Phase parks at 0 while idle so the first bit period starts cleanly on accept
    always_ff @(posedge clk_200khz or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (!run || phase == PHASE_W'(2 * H - 1)) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    assign scl         = !run || (phase >= PHASE_W'(H));
    assign drive_tick  = run && (phase == PHASE_W'(H / 2));
    assign sample_tick = run && (phase == PHASE_W'(H + H / 2));
    assign bit_end     = run && (phase == PHASE_W'(2 * H - 1));

endmodule

// File: rtl/i2c_master_burst_reader.sv
// rtl/i2c_master_burst_reader.sv - I2C master reading a burst of registers from a 7-bit slave
module i2c_master_burst_reader
    import i2c_pkg::*;
#(
    parameter int SCL_HALF_TICKS = DEFAULT_SCL_HALF_TICKS,
    parameter int MAX_BYTES      = 4,
    parameter int LEN_W          = $clog2(MAX_BYTES) + 1
) (
    input  logic                   clk_200khz,
    input  logic                   rst,
    input  logic                   start,
    input  logic [6:0]             slave_addr,
    input  logic [7:0]             reg_addr,
    input  logic [LEN_W-1:0]       len,
    output logic                   scl,
    inout  wire                    sda,
    output logic                   sda_dir,
    output logic                   busy,
    output logic                   done,
    output logic                   nack_err,
    output logic [8*MAX_BYTES-1:0] data_out
);

    localparam int PHASE_W = $clog2(2 * SCL_HALF_TICKS);

    i2c_state_t         state, state_nxt;
    logic [PHASE_W-1:0] phase;
    logic               scl_t, drive_tick, sample_tick, bit_end;
    logic               run, accept, byte_done, last_byte;
    logic [2:0]         bit_cnt;
    logic [LEN_W-1:0]   byte_cnt, n_bytes, len_clamped;
    logic [6:0]         slave_q;
    logic [7:0]         reg_q, tx_byte, rx_shift;
    logic               out_bit, ack_bit;

    i2c_bit_timer #(
        .SCL_HALF_TICKS(SCL_HALF_TICKS),
        .PHASE_W       (PHASE_W)
    ) u_bit_timer (
        .clk_200khz (clk_200khz),
        .rst        (rst),
        .run        (run),
        .phase      (phase),
        .scl        (scl_t),
        .drive_tick (drive_tick),
        .sample_tick(sample_tick),
        .bit_end    (bit_end)
    );

    assign run       = (state != IDLE);
    assign busy      = run;
    assign accept    = (state == IDLE) && start && (phase == '0);
    assign byte_done = (bit_cnt == 3'd7);
    assign last_byte = (byte_cnt == n_bytes - 1'b1);
    // SCL stays high through the whole START period
    assign scl       = (state == START) ? 1'b1 : scl_t;
    assign sda       = (sda_dir && out_bit == 1'b0) ? 1'b0 : 1'bz;

    always_comb begin
        if (len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (len > LEN_W'(MAX_BYTES)) begin
            len_clamped = LEN_W'(MAX_BYTES);
        end else begin
            len_clamped = len;
        end
    end

    always_comb begin
        tx_byte = 8'h00;
        case (state)
            ADDR_W:  tx_byte = {slave_q, I2C_WRITE};
            REG:     tx_byte = reg_q;
            ADDR_R:  tx_byte = {slave_q, I2C_READ};
            default: tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk_200khz or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = START;
            START:   if (bit_end) state_nxt = ADDR_W;
            ADDR_W:  if (bit_end && byte_done) state_nxt = ACK1;
            ACK1:    if (bit_end) state_nxt = (ack_bit == NACK) ? STOP : REG;
            REG:     if (bit_end && byte_done) state_nxt = ACK2;
            ACK2:    if (bit_end) state_nxt = (ack_bit == NACK) ? STOP : RSTART;
            RSTART:  if (bit_end) state_nxt = ADDR_R;
            ADDR_R:  if (bit_end && byte_done) state_nxt = ACK3;
            ACK3:    if (bit_end) state_nxt = (ack_bit == NACK) ? STOP : RDATA;
            RDATA:   if (bit_end && byte_done) state_nxt = MACK;
            MACK:    if (bit_end) state_nxt = last_byte ? STOP : RDATA;
            STOP:    if (bit_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_200khz or posedge rst) begin
        if (rst) begin
            slave_q  <= '0;
            reg_q    <= '0;
            n_bytes  <= LEN_W'(1);
            byte_cnt <= '0;
            bit_cnt  <= '0;
            rx_shift <= '0;
            data_out <= '0;
            nack_err <= 1'b0;
            done     <= 1'b0;
            ack_bit  <= ACK;
            sda_dir  <= 1'b0;
            out_bit  <= 1'b1;
        end else begin
            done <= 1'b0;
            if (accept) begin
                slave_q  <= slave_addr;
                reg_q    <= reg_addr;
                n_bytes  <= len_clamped;
                byte_cnt <= '0;
                data_out <= '0;
                nack_err <= 1'b0;
            end
            if (bit_end) begin
                bit_cnt <= (state_nxt == state) ? bit_cnt + 3'd1 : 3'd0;
                if (state == MACK) begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
                if (state == RDATA && byte_done) begin
                    for (int i = 0; i < MAX_BYTES; i++) begin
                        if (byte_cnt == LEN_W'(i)) data_out[8*i +: 8] <= rx_shift;
                    end
                end
                if (state == STOP) begin
                    done <= 1'b1;
                end
            end
            if (drive_tick) begin
                case (state)
                    ADDR_W, REG, ADDR_R: begin
                        sda_dir <= 1'b1;
                        out_bit <= tx_byte[3'd7 - bit_cnt];
                    end
                    // Releasing SDA after the final byte is the master NACK
                    MACK: begin
                        sda_dir <= !last_byte;
                        out_bit <= ACK;
                    end
                    STOP: begin
                        sda_dir <= 1'b1;
                        out_bit <= 1'b0;
                    end
                    START: ;
                    default: sda_dir <= 1'b0;
                endcase
            end
            if (sample_tick) begin
                case (state)
                    START, RSTART: begin
                        sda_dir <= 1'b1;
                        out_bit <= 1'b0;
                    end
                    STOP: sda_dir <= 1'b0;
                    ACK1, ACK2, ACK3: begin
                        ack_bit <= sda;
                        if (sda == NACK) nack_err <= 1'b1;
                    end
                    RDATA: rx_shift <= {rx_shift[6:0], sda};
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_burst_reader.sv
// tb/tb_i2c_master_burst_reader.sv - self-checking bench with a behavioural I2C slave
module tb_i2c_master_burst_reader;

    localparam int H    = 10;
    localparam int MAXB = 4;
    localparam int LW   = 3;

    logic          clk_200khz = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [6:0]    slave_addr = '0;
    logic [7:0]    reg_addr = '0;
    logic [LW-1:0] len = '0;
    logic          scl, sda_dir, busy, done, nack_err;
    logic [31:0]   data_out;
    wire           sda;
    logic          drv_low = 1'b0;

    pullup (sda);
    assign sda = drv_low ? 1'b0 : 1'bz;

    always #5 clk_200khz = ~clk_200khz;

    i2c_master_burst_reader #(
        .SCL_HALF_TICKS(H),
        .MAX_BYTES     (MAXB),
        .LEN_W         (LW)
    ) dut (
        .clk_200khz(clk_200khz),
        .rst       (rst),
        .start     (start),
        .slave_addr(slave_addr),
        .reg_addr  (reg_addr),
        .len       (len),
        .scl       (scl),
        .sda       (sda),
        .sda_dir   (sda_dir),
        .busy      (busy),
        .done      (done),
        .nack_err  (nack_err),
        .data_out  (data_out)
    );

    int checks = 0;
    int failures = 0;
    int cur_vec = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL vec%0d %s actual=%0h expected=%0h", cur_vec, name, act, exp);
        end
    endtask

    // Behavioural slave plus bus monitor, sampled away from the DUT clock edge
    logic [7:0] mem [256];
    logic [6:0] sl_addr = 7'h68;
    logic [7:0] bus_bytes [$];
    logic       bus_acks [$];
    int         start_cnt = 0, stop_cnt = 0;
    int         bitn = 0;
    logic [7:0] sh = '0, tx = '0, ptr = '0;
    bit         frame_first = 0, addressed = 0, reading = 0, pending_tx = 0, tx_active = 0;
    logic       last_ack = 1'b1, prev_scl = 1'b1, prev_sda = 1'b1;

    always @(negedge clk_200khz) begin
        if (rst) begin
            bitn = 0; drv_low = 1'b0; tx_active = 0; pending_tx = 0;
            addressed = 0; frame_first = 0; prev_scl = 1'b1; prev_sda = 1'b1;
        end else begin
            if (scl && prev_scl && prev_sda && !sda) begin
                start_cnt++; bitn = 0; frame_first = 1; sh = '0;
            end else if (scl && prev_scl && !prev_sda && sda) begin
                stop_cnt++; bitn = 0; addressed = 0; tx_active = 0; pending_tx = 0;
            end else if (scl && !prev_scl) begin
                if (bitn < 8) begin
                    sh = {sh[6:0], sda};
                    bitn++;
                    if (bitn == 8) bus_bytes.push_back(sh);
                end else if (bitn == 8) begin
                    bus_acks.push_back(sda);
                    last_ack = sda;
                    bitn = 9;
                end
            end else if (!scl && prev_scl) begin
                if (bitn == 8) begin
                    if (frame_first) begin
                        frame_first = 0;
                        addressed = (sh[7:1] == sl_addr);
                        reading = sh[0];
                        drv_low = addressed;
                        pending_tx = addressed && sh[0];
                    end else if (addressed && !reading) begin
                        ptr = sh;
                        drv_low = 1'b1;
                    end else begin
                        drv_low = 1'b0;
                    end
                end else if (bitn == 9) begin
                    bitn = 0;
                    drv_low = 1'b0;
                    if (pending_tx || (tx_active && last_ack == 1'b0)) begin
                        tx = mem[ptr];
                        ptr = ptr + 8'd1;
                        tx_active = 1;
                        drv_low = !tx[7];
                    end else begin
                        tx_active = 0;
                    end
                    pending_tx = 0;
                end else if (bitn >= 1 && bitn <= 7 && tx_active) begin
                    drv_low = !tx[7-bitn];
                end
            end
            prev_scl = scl;
            prev_sda = sda;
        end
    end

    function automatic int clamp_len(input int l);
        return (l == 0) ? 1 : ((l > MAXB) ? MAXB : l);
    endfunction

    task automatic run_txn(input logic [6:0] taddr, input logic [7:0] raddr, input int ln,
                           input int restart_at, input logic [31:0] exp_data,
                           input bit exp_nack, input int exp_cycles);
        logic [7:0] exp_bytes [$];
        logic       exp_acks [$];
        bit         hit;
        int         n, busy_cyc, done_cnt, done_busy, idle_after, c;
        logic [7:0] a;
        hit = (taddr == sl_addr);
        n = clamp_len(ln);
        exp_bytes.push_back({taddr, 1'b0});
        if (hit) begin
            exp_bytes.push_back(raddr);
            exp_bytes.push_back({taddr, 1'b1});
            for (int i = 0; i < 3; i++) exp_acks.push_back(1'b0);
            for (int i = 0; i < n; i++) begin
                a = raddr + 8'(i);
                exp_bytes.push_back(mem[a]);
                exp_acks.push_back(i == n - 1);
            end
        end else begin
            exp_acks.push_back(1'b1);
        end
        bus_bytes.delete(); bus_acks.delete(); start_cnt = 0; stop_cnt = 0;
        slave_addr = taddr; reg_addr = raddr; len = LW'(ln);
        @(negedge clk_200khz) start = 1'b1;
        @(negedge clk_200khz);
        busy_cyc = 0; done_cnt = 0; done_busy = 0; idle_after = 0; c = 0;
        while (c < 4000 && idle_after < 30) begin
            start = (c == restart_at);
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                if (busy) done_busy++;
            end
            if (done_cnt > 0) idle_after++;
            c++;
            @(negedge clk_200khz);
        end
        start = 1'b0;
        check("done_count", done_cnt, 1);
        check("done_with_busy_high", done_busy, 0);
        check("busy_cycles", busy_cyc, exp_cycles);
        check("data_out", data_out, exp_data);
        check("nack_err", nack_err, exp_nack);
        check("idle_scl_dir", {scl, sda_dir}, 2'b10);
        check("bus_byte_count", bus_bytes.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < bus_bytes.size(); i++)
            check($sformatf("bus_byte%0d", i), bus_bytes[i], exp_bytes[i]);
        check("bus_ack_count", bus_acks.size(), exp_acks.size());
        for (int i = 0; i < exp_acks.size() && i < bus_acks.size(); i++)
            check($sformatf("bus_ack%0d", i), bus_acks[i], exp_acks[i]);
        check("start_conditions", start_cnt, hit ? 2 : 1);
        check("stop_conditions", stop_cnt, 1);
    endtask

    typedef struct {
        logic [6:0]  taddr;
        logic [7:0]  raddr;
        int          ln;
        int          restart_at;
        logic [31:0] mem_word;
        logic [31:0] exp_data;
        bit          exp_nack;
        int          exp_cycles;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int         ln, n, busy_cyc, done_seen;
        logic [6:0] taddr;
        logic [7:0] raddr, a;
        logic [31:0] exp_data;
        bit         hit;

        vecs[0] = '{7'h68, 8'h3C, 1, -1, 32'h0000_00A5, 32'h0000_00A5, 1'b0, 780};
        vecs[1] = '{7'h68, 8'h10, 4, -1, 32'h4433_2211, 32'h4433_2211, 1'b0, 1320};
        vecs[2] = '{7'h50, 8'h3C, 1, -1, 32'h0000_00A5, 32'h0000_0000, 1'b1, 220};
        vecs[3] = '{7'h68, 8'h80, 0, -1, 32'hDDCC_BBAA, 32'h0000_00AA, 1'b0, 780};
        vecs[4] = '{7'h68, 8'h90, 7, -1, 32'h0403_0201, 32'h0403_0201, 1'b0, 1320};
        vecs[5] = '{7'h68, 8'h20, 2, 300, 32'h0000_7E81, 32'h0000_7E81, 1'b0, 960};
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        repeat (3) @(negedge clk_200khz);
        check("reset_scl", scl, 1'b1);
        check("reset_sda", sda, 1'b1);
        check("reset_sda_dir", sda_dir, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_nack_err", nack_err, 1'b0);
        check("reset_data_out", data_out, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk_200khz);

        for (int v = 0; v < 6; v++) begin
            cur_vec = v;
            sl_addr = 7'h68;
            for (int b = 0; b < 4; b++) begin
                a = vecs[v].raddr + 8'(b);
                mem[a] = vecs[v].mem_word[8*b +: 8];
            end
            run_txn(vecs[v].taddr, vecs[v].raddr, vecs[v].ln, vecs[v].restart_at,
                    vecs[v].exp_data, vecs[v].exp_nack, vecs[v].exp_cycles);
        end

        for (int r = 0; r < 10; r++) begin
            cur_vec = 100 + r;
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            sl_addr = 7'($urandom);
            taddr = ($urandom_range(0, 3) == 0) ? (sl_addr ^ 7'($urandom_range(1, 127))) : sl_addr;
            raddr = 8'($urandom);
            ln = $urandom_range(0, 7);
            hit = (taddr == sl_addr);
            n = clamp_len(ln);
            exp_data = '0;
            if (hit) begin
                for (int i = 0; i < n; i++) begin
                    a = raddr + 8'(i);
                    exp_data = exp_data | (32'(mem[a]) << (8 * i));
                end
            end
            run_txn(taddr, raddr, ln, -1, exp_data, !hit, hit ? (30 + 9 * n) * 2 * H : 11 * 2 * H);
        end

        // Reset in the middle of the second data byte of a three-byte burst
        cur_vec = 200;
        sl_addr = 7'h68;
        mem[8'h40] = 8'h5C; mem[8'h41] = 8'h00; mem[8'h42] = 8'h33;
        slave_addr = 7'h68; reg_addr = 8'h40; len = LW'(3);
        @(negedge clk_200khz) start = 1'b1;
        @(negedge clk_200khz) start = 1'b0;
        busy_cyc = 0;
        for (int c = 0; c < 2000 && busy_cyc < 860; c++) begin
            if (busy) busy_cyc++;
            if (busy_cyc < 860) @(negedge clk_200khz);
        end
        check("pre_reset_byte0", data_out[7:0], 8'h5C);
        rst = 1'b1;
        #1;
        check("mid_reset_scl", scl, 1'b1);
        check("mid_reset_sda_dir", sda_dir, 1'b0);
        check("mid_reset_busy", busy, 1'b0);
        check("mid_reset_data_out", data_out, 32'h0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk_200khz);
            if (done) done_seen++;
        end
        rst = 1'b0;
        repeat (100) begin
            @(negedge clk_200khz);
            if (done || busy) done_seen++;
        end
        check("no_done_after_reset", done_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
